// File: rtl/sort_stream_port.sv
// Streaming wrapper around the iterative compare sorter: gathers a frame from a
// valid/ready input, launches one sort, then drains the sorted words (minus pads).
module sort_stream_port #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DATA_CNT   = 1024,
  parameter string       COM_STYLE  = "UP",
  parameter int unsigned CNT_W      = $clog2(DATA_CNT + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic                           s_last,
  output logic [DATA_WIDTH*DATA_CNT-1:0] sort_data,
  output logic                           sort_en,
  input  logic                           sort_done,
  input  logic [DATA_WIDTH*DATA_CNT-1:0] sort_result,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic [CNT_W-1:0]               m_index,
  output logic                           busy
);

  localparam int unsigned IDX_W = $clog2(DATA_CNT);

  // Pads must sort to the tail: largest value for ascending, smallest for descending.
  localparam logic [DATA_WIDTH-1:0] PAD =
    (COM_STYLE == "DOWN") ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DATA_CNT - 1);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]      rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]      frame_len_q, frame_len_d;
  logic [DATA_WIDTH-1:0] result_q [DATA_CNT];

  logic                  s_acc, m_hs, frame_end, capture;
  logic                  s_ready_d, sort_en_d, m_valid_d, m_last_d, busy_d;
  logic [CNT_W-1:0]      m_index_d;
  logic [DATA_WIDTH-1:0] m_data_d;

  assign s_acc     = s_valid & s_ready;
  assign m_hs      = m_valid & m_ready;
  assign frame_end = s_acc & (s_last | (wr_cnt_q == LAST_SLOT));
  assign capture   = (state_q == WAIT) & sort_done;

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_idx_d    = rd_idx_q;
    frame_len_d = frame_len_q;
    m_data_d    = m_data;
    case (state_q)
      FILL: begin
        if (s_acc) wr_cnt_d = wr_cnt_q + CNT_W'(1);
        if (frame_end) begin
          frame_len_d = wr_cnt_q + CNT_W'(1);
          state_d     = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (sort_done) begin
          rd_idx_d = '0;
          m_data_d = sort_result[DATA_WIDTH-1:0];
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (m_hs) begin
          if (m_last) begin
            wr_cnt_d = '0;
            state_d  = FILL;
          end else begin
            rd_idx_d = rd_idx_q + CNT_W'(1);
            m_data_d = result_q[rd_idx_d[IDX_W-1:0]];
          end
        end
      end
      default: state_d = FILL;
    endcase
    s_ready_d = (state_d == FILL);
    sort_en_d = (state_d == LAUNCH);
    m_valid_d = (state_d == DRAIN);
    m_index_d = (state_d == DRAIN) ? rd_idx_d : '0;
    m_last_d  = (state_d == DRAIN) && (rd_idx_d == (frame_len_d - CNT_W'(1)));
    busy_d    = (state_d != FILL) || (wr_cnt_d != '0);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wr_cnt_q    <= '0;
      rd_idx_q    <= '0;
      frame_len_q <= '0;
      s_ready     <= 1'b1;
      sort_en     <= 1'b0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_index     <= '0;
      m_data      <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_idx_q    <= rd_idx_d;
      frame_len_q <= frame_len_d;
      s_ready     <= s_ready_d;
      sort_en     <= sort_en_d;
      m_valid     <= m_valid_d;
      m_last      <= m_last_d;
      m_index     <= m_index_d;
      m_data      <= m_data_d;
      busy        <= busy_d;
    end
  end

  // Frame buffer: write the accepted word, pad the unused tail when the frame closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sort_data <= '0;
    end else begin
      for (int i = 0; i < int'(DATA_CNT); i++) begin
        if (s_acc && (wr_cnt_q == CNT_W'(i)))
          sort_data[i*DATA_WIDTH +: DATA_WIDTH] <= s_data;
        else if (frame_end && (CNT_W'(i) > wr_cnt_q))
          sort_data[i*DATA_WIDTH +: DATA_WIDTH] <= PAD;
      end
    end
  end

  // Result buffer only feeds the drain mux, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < int'(DATA_CNT); i++)
        result_q[i] <= sort_result[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_sort_stream_port.sv
// Directed bench for sort_stream_port: an ascending and a descending instance,
// each driven by a behavioural sorter with a fixed launch-to-done latency.
module tb_sort_stream_port;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  s_data;
  logic          s_valid, s_last, m_ready, inj_done, sel;

  logic          s_ready_a, sort_en_a, m_valid_a, m_last_a, busy_a, sort_done_a, done_a;
  logic          s_ready_b, sort_en_b, m_valid_b, m_last_b, busy_b, sort_done_b, done_b;
  logic [W*N-1:0] sort_data_a, sort_data_b, res_a, res_b;
  logic [W-1:0]  m_data_a, m_data_b;
  logic [CW-1:0] m_index_a, m_index_b;
  int            lat_a, lat_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign sort_done_a = done_a | (inj_done & ~sel);
  assign sort_done_b = done_b | (inj_done & sel);

  sort_stream_port #(.DATA_WIDTH(W), .DATA_CNT(N), .COM_STYLE("UP"), .CNT_W(CW)) u_up (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid & ~sel), .s_ready(s_ready_a), .s_last(s_last),
    .sort_data(sort_data_a), .sort_en(sort_en_a), .sort_done(sort_done_a), .sort_result(res_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready & ~sel), .m_last(m_last_a),
    .m_index(m_index_a), .busy(busy_a)
  );

  sort_stream_port #(.DATA_WIDTH(W), .DATA_CNT(N), .COM_STYLE("DOWN"), .CNT_W(CW)) u_down (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid & sel), .s_ready(s_ready_b), .s_last(s_last),
    .sort_data(sort_data_b), .sort_en(sort_en_b), .sort_done(sort_done_b), .sort_result(res_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready & sel), .m_last(m_last_b),
    .m_index(m_index_b), .busy(busy_b)
  );

  // Observation mux onto the instance currently under test
  logic          s_ready_o, sort_en_o, m_valid_o, m_last_o, busy_o, sort_done_o;
  logic [W*N-1:0] sort_data_o;
  logic [W-1:0]  m_data_o;
  logic [CW-1:0] m_index_o;
  assign s_ready_o   = sel ? s_ready_b   : s_ready_a;
  assign sort_en_o   = sel ? sort_en_b   : sort_en_a;
  assign m_valid_o   = sel ? m_valid_b   : m_valid_a;
  assign m_last_o    = sel ? m_last_b    : m_last_a;
  assign busy_o      = sel ? busy_b      : busy_a;
  assign sort_done_o = sel ? sort_done_b : sort_done_a;
  assign sort_data_o = sel ? sort_data_b : sort_data_a;
  assign m_data_o    = sel ? m_data_b    : m_data_a;
  assign m_index_o   = sel ? m_index_b   : m_index_a;

  function automatic logic [W*N-1:0] sort8(input logic [W*N-1:0] v, input bit up);
    logic [W-1:0] a [N];
    logic [W-1:0] t;
    logic [W*N-1:0] r;
    for (int i = 0; i < int'(N); i++) a[i] = v[i*W +: W];
    for (int i = 0; i < int'(N) - 1; i++)
      for (int j = 0; j < int'(N) - 1 - i; j++)
        if (up ? (a[j] > a[j+1]) : (a[j] < a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int i = 0; i < int'(N); i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  // Sorter models: done pulses four cycles after the launch strobe is sampled
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_a <= 0; done_a <= 1'b0; res_a <= '0;
    end else begin
      done_a <= 1'b0;
      if (sort_en_a) begin
        lat_a <= 4; res_a <= sort8(sort_data_a, 1'b1);
      end else if (lat_a != 0) begin
        lat_a <= lat_a - 1;
        if (lat_a == 1) done_a <= 1'b1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_b <= 0; done_b <= 1'b0; res_b <= '0;
    end else begin
      done_b <= 1'b0;
      if (sort_en_b) begin
        lat_b <= 4; res_b <= sort8(sort_data_b, 1'b0);
      end else if (lat_b != 0) begin
        lat_b <= lat_b - 1;
        if (lat_b == 1) done_b <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one word and hold it until accepted; entered and left on a negedge.
  task automatic send(input logic [W-1:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready_o && n < 50) begin @(negedge clk); n++; end
    chk("send_ready", 64'(s_ready_o), 64'd1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!sort_done_o && n < 50) begin @(negedge clk); n++; end
    chk("done_seen", 64'(sort_done_o), 64'd1);
    chk("mvalid_in_done_cycle", 64'(m_valid_o), 64'd0);
    @(negedge clk);
    chk("mvalid_after_done", 64'(m_valid_o), 64'd1);
  endtask

  // Expect one output word; with bp set, ready is withheld at random (always on the first try).
  task automatic recv(input logic [W-1:0] d, input int idx, input logic last, input bit bp);
    int n = 0;
    bit go;
    do begin
      go = bp ? ((n == 0) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
      m_ready = go;
      chk("m_valid", 64'(m_valid_o), 64'd1);
      chk("m_data", 64'(m_data_o), 64'(d));
      chk("m_index", 64'(m_index_o), 64'(idx));
      chk("m_last", 64'(m_last_o), 64'(last));
      chk("s_ready_drain", 64'(s_ready_o), 64'd0);
      @(negedge clk);
      n++;
    end while (!go && n < 50);
    m_ready = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mvalid"}, 64'(m_valid_o), 64'd0);
    chk({tag, "_sready"}, 64'(s_ready_o), 64'd1);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    m_ready = 1'b0; inj_done = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready_o), 64'd1);
    chk("rst_sort_en", 64'(sort_en_o), 64'd0);
    chk("rst_m_valid", 64'(m_valid_o), 64'd0);
    chk("rst_m_last", 64'(m_last_o), 64'd0);
    chk("rst_m_index", 64'(m_index_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_sort_data", sort_data_o, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full 8-word ascending frame
    send(8'd5, 1'b0); chk("busy_mid_fill", 64'(busy_o), 64'd1);
    send(8'd3, 1'b0); send(8'd7, 1'b0); send(8'd1, 1'b0);
    send(8'd0, 1'b0); send(8'd6, 1'b0); send(8'd2, 1'b0); send(8'd4, 1'b1);
    chk("t1_sort_en", 64'(sort_en_o), 64'd1);
    chk("t1_s_ready", 64'(s_ready_o), 64'd0);
    chk("t1_sort_data", sort_data_o, 64'h0402060001070305);
    @(negedge clk);
    chk("t1_sort_en_pulse", 64'(sort_en_o), 64'd0);
    wait_done();
    for (int i = 0; i < 8; i++) recv(8'(i), i, (i == 7), 1'b0);
    chk_idle("t1_end");

    // Short ascending frame, pads to 0xFF
    send(8'd9, 1'b0); send(8'd2, 1'b0); send(8'd5, 1'b1);
    chk("t2_sort_data", sort_data_o, 64'hFFFFFFFFFF050209);
    wait_done();
    recv(8'd2, 0, 1'b0, 1'b0);
    recv(8'd5, 1, 1'b0, 1'b0);
    recv(8'd9, 2, 1'b1, 1'b0);
    chk_idle("t2_end");

    // Descending instance, pads to 0x00
    sel = 1'b1;
    send(8'd4, 1'b0); send(8'd200, 1'b1);
    chk("t3_sort_data", sort_data_o, 64'h000000000000C804);
    wait_done();
    recv(8'd200, 0, 1'b0, 1'b0);
    recv(8'd4, 1, 1'b1, 1'b0);
    chk_idle("t3_end");
    sel = 1'b0;

    // Nine words without last: truncation at eight, ninth waits for the next frame
    for (int i = 0; i < 8; i++) send(8'(17 - i), 1'b0);
    chk("t4_sort_en", 64'(sort_en_o), 64'd1);
    chk("t4_sort_data", sort_data_o, 64'h0A0B0C0D0E0F1011);
    s_valid = 1'b1; s_data = 8'd99; s_last = 1'b1;
    chk("t4_word9_blocked", 64'(s_ready_o), 64'd0);
    wait_done();
    for (int i = 0; i < 8; i++) recv(8'(10 + i), i, (i == 7), 1'b0);
    chk("t4_ready_after_drain", 64'(s_ready_o), 64'd1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    chk("t4_single_launch", 64'(sort_en_o), 64'd1);
    chk("t4_single_data", sort_data_o, 64'hFFFFFFFFFFFFFF63);
    wait_done();
    recv(8'd99, 0, 1'b1, 1'b0);
    chk_idle("t4_end");

    // Random output backpressure with duplicate values
    send(8'd3, 1'b0); send(8'd3, 1'b0); send(8'd8, 1'b0); send(8'd1, 1'b0); send(8'd200, 1'b1);
    chk("t5_sort_data", sort_data_o, 64'hFFFFFFC801080303);
    wait_done();
    recv(8'd1, 0, 1'b0, 1'b1);
    recv(8'd3, 1, 1'b0, 1'b1);
    recv(8'd3, 2, 1'b0, 1'b1);
    recv(8'd8, 3, 1'b0, 1'b1);
    recv(8'd200, 4, 1'b1, 1'b1);
    chk_idle("t5_end");

    // Reset while waiting on the sorter, then a stale done strobe
    send(8'd7, 1'b0); send(8'd6, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle("t6_in_reset");
    chk("t6_rst_sort_data", sort_data_o, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    chk_idle("t6_stale_done");
    send(8'd2, 1'b0); send(8'd1, 1'b1);
    chk("t6_sort_data", sort_data_o, 64'hFFFFFFFFFFFF0102);
    wait_done();
    recv(8'd1, 0, 1'b0, 1'b0);
    recv(8'd2, 1, 1'b1, 1'b0);
    chk_idle("t6_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
